// File: rtl/fft_bfly_sequencer.sv
// Address/stage sequencer for a 256-point radix-2 FFT: walks 8 stages of 128 butterflies,
// throttles issue by writeback credits and strobes the external twiddle index counter.
module fft_bfly_sequencer #(
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       start,
  input  logic       bfly_ready,
  input  logic       wb_ack,
  output logic       bfly_valid,
  output logic [7:0] addr_top,
  output logic [7:0] addr_bot,
  output logic [3:0] stage_count_out,
  output logic       k_enable,
  output logic       k_clear,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, DRAIN, DONE} state_e;

  localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

  state_e     state_q;
  logic [2:0] stage_q;
  logic [6:0] b_q;
  logic [3:0] outst_q, outst_d;
  logic       hs, ack_eff;
  logic [7:0] b_ext, half, top;

  assign bfly_valid      = (state_q == ISSUE) && (outst_q < MAX_OUT);
  assign hs              = bfly_valid && bfly_ready;
  assign k_enable        = hs;
  assign k_clear         = (state_q == CLEAR);
  assign busy            = (state_q != IDLE);
  assign done            = (state_q == DONE);
  assign stage_count_out = {1'b0, stage_q};

  // An ack with nothing in flight (and nothing issuing) is dropped so the credit count never wraps.
  assign ack_eff = wb_ack && ((outst_q != 4'd0) || hs);

  always_comb begin
    outst_d = outst_q;
    if (hs && !ack_eff)      outst_d = outst_q + 4'd1;
    else if (!hs && ack_eff) outst_d = outst_q - 4'd1;
  end

  // Insert a zero bit at position 'stage' of b to get the upper operand; the lower sits half above.
  always_comb begin
    b_ext = {1'b0, b_q};
    half  = 8'd1 << stage_q;
    top   = ((b_ext >> stage_q) << (4'({1'b0, stage_q}) + 4'd1)) | (b_ext & (half - 8'd1));
  end

  assign addr_top = busy ? top : 8'd0;
  assign addr_bot = busy ? (top + half) : 8'd0;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      stage_q <= 3'd0;
      b_q     <= 7'd0;
      outst_q <= 4'd0;
    end else begin
      outst_q <= outst_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= CLEAR;
            stage_q <= 3'd0;
            b_q     <= 7'd0;
          end
        end
        CLEAR: state_q <= ISSUE;
        ISSUE: begin
          if (hs) begin
            b_q <= b_q + 7'd1;
            if (b_q == 7'd127) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (outst_d == 4'd0) begin
            if (stage_q == 3'd7) begin
              state_q <= DONE;
            end else begin
              state_q <= CLEAR;
              stage_q <= stage_q + 3'd1;
              b_q     <= 7'd0;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fft_bfly_sequencer.md
FFT_BFLY_SEQUENCER -- requirements
Module: fft_bfly_sequencer

Interface
REQ-001 Parameter: MAX_OUTSTANDING, default 4, maximum number of issued butterflies not yet acknowledged by writeback (legal range 1..15).
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 nrst  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  single-cycle request to run one complete 256-point transform; sampled only in IDLE.
REQ-005 bfly_ready  input  1  butterfly datapath accepts the presented butterfly this cycle.
REQ-006 wb_ack  input  1  one butterfly writeback completed this cycle.
REQ-007 bfly_valid  output  1  addr_top/addr_bot/stage_count_out describe a butterfly to issue.
REQ-008 addr_top  output  8  sample-RAM address of the upper butterfly operand.
REQ-009 addr_bot  output  8  sample-RAM address of the lower butterfly operand.
REQ-010 stage_count_out  output  4  current stage, 0..7; drives the twiddle index counter.
REQ-011 k_enable  output  1  twiddle index advance strobe.
REQ-012 k_clear  output  1  twiddle index clear strobe.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse at transform completion.

Function
REQ-015 The FSM SHALL have states IDLE, CLEAR, ISSUE, DRAIN, DONE.
REQ-016 IDLE->CLEAR on start=1, loading stage=0 and butterfly counter b=0; start SHALL be ignored in all other states.
REQ-017 CLEAR SHALL last exactly one cycle with k_clear=1 and bfly_valid=0, then go to ISSUE.
REQ-018 In ISSUE, bfly_valid SHALL be 1 when outstanding < MAX_OUTSTANDING, else 0.
REQ-019 A handshake is bfly_valid && bfly_ready; on a handshake b SHALL increment, and at b=127 the FSM SHALL go to DRAIN.
REQ-020 k_enable SHALL equal the handshake (combinational), so the downstream counter (wraps at 2^stage) tracks k = b mod 2^stage.
REQ-021 For half=2^stage: addr_top = ((b >> stage) << (stage+1)) | (b & (half-1)); addr_bot = addr_top + half; both decoded from registered b and stage, 8-bit, never overflow.
REQ-022 outstanding (4 bits) SHALL +1 on handshake, -1 on wb_ack, hold when both occur together; wb_ack with outstanding=0 and no handshake SHALL be ignored (no underflow).
REQ-023 DRAIN SHALL exit when the next outstanding value is 0: to DONE if stage=7, else to CLEAR with stage+1, b=0.
REQ-024 DONE SHALL assert done=1 for exactly one cycle, then go to IDLE; stage_count_out holds 7 until the next start.
REQ-025 k_clear and k_enable SHALL never be high in the same cycle; bfly_valid, k_enable and k_clear SHALL be 0 outside CLEAR/ISSUE as specified.
REQ-026 bfly_valid deassertion SHALL occur only via REQ-018 or leaving ISSUE; while bfly_ready=0, addresses SHALL hold stable.

Reset
REQ-027 nrst=0 SHALL immediately force state=IDLE, stage=0, b=0, outstanding=0, and every output to 0 (addr_top, addr_bot, stage_count_out, bfly_valid, k_enable, k_clear, busy, done).
REQ-028 Reset asserted mid-transform SHALL abort it with no done pulse; a new start after release SHALL begin again at stage 0.

Verification
REQ-029 bfly_ready=1, wb_ack tied to handshake, start pulse -> each stage spends 1 CLEAR + 128 ISSUE + 1 DRAIN cycles; done high for one cycle exactly 1040 edges after the edge sampling start; busy high throughout.
REQ-030 Address check: stage 0 pairs (0,1),(2,3)..(254,255); stage 1 (0,2),(1,3),(4,6); stage 7 (0,128)..(127,255); every address 0..255 appears exactly once per stage.
REQ-031 wb_ack withheld, MAX_OUTSTANDING=4 -> exactly 4 handshakes then bfly_valid=0; one wb_ack -> one more issue; DRAIN holds until outstanding returns to 0.
REQ-032 bfly_ready toggled randomly -> k_enable count per stage = 128, addresses stable while stalled, k_clear exactly once per stage before the first k_enable.
REQ-033 start re-pulsed during ISSUE of stage 3 -> no effect on stage/b; spurious wb_ack in IDLE -> outstanding stays 0.
REQ-034 nrst pulsed during stage 5 ISSUE -> all outputs 0 asynchronously, no done; subsequent start -> stage_count_out=0, addr_top=0, addr_bot=1.
